debug_access_ctrl: RTL

//  Arbitrates the shared 32-bit accumulator datapath (one-hot ops: LOAD 0001, ADD 0010, SUB 0100, XOR 1000)

---
 rtl/debug_access_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/debug_access_ctrl.sv
// Purpose : arbitrates the shared accumulator datapath between the host and a key-gated debug port.
// Latency : accepted command drives dp_control/dp_data next cycle; debug response pulses next cycle.
// Backpr. : valid/ready per requester; ready is combinational, for the arbitration winner only.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   host_valid/op/data -> host_ready   host datapath command (op: 00 LOAD, 01 ADD, 10 SUB, 11 XOR)
//   dbg_valid/op/data  -> dbg_ready    debug command (0xx datapath op, 100 READ, others reserved)
//   dbg_unlock, dbg_key, dbg_relock    unlock attempt / forced relock
//   dbg_rsp_valid/data/err             one-cycle response per accepted debug command
//   dbg_unlocked                       session is open
//   dp_control, dp_data <- dp_result   one-hot op + operand to datapath, accumulator value back
module debug_access_ctrl #(
  parameter logic [31:0] UNLOCK_KEY      = 32'hA5C3_0F1E,
  parameter int unsigned MAX_FAIL        = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 256,
  parameter int unsigned SESSION_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_valid,
  input  logic [1:0]  host_op,
  input  logic [31:0] host_data,
  output logic        host_ready,
  input  logic        dbg_valid,
  input  logic [2:0]  dbg_op,
  input  logic [31:0] dbg_data,
  output logic        dbg_ready,
  input  logic        dbg_unlock,
  input  logic [31:0] dbg_key,
  input  logic        dbg_relock,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rsp_data,
  output logic        dbg_rsp_err,
  output logic        dbg_unlocked,
  output logic [3:0]  dp_control,
  output logic [31:0] dp_data,
  input  logic [31:0] dp_result
);

  localparam int unsigned LO_W   = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(SESSION_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_CHECK    = 2'd1,
    S_UNLOCKED = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_key;
  logic [3:0]          r_fail;
  logic [LO_W-1:0]     r_lo_cnt;
  logic [IDLE_W-1:0]   r_idle;
  logic                r_rr_ptr;   // 0: host wins next contention, 1: debug wins
  logic [3:0]          r_dp_control;
  logic [31:0]         r_dp_data;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic                r_rsp_read;

  logic        w_unlocked;
  logic        w_permit;
  logic        w_dbg_is_dp;
  logic        w_dbg_is_read;
  logic        w_host_req;
  logic        w_dbg_dp_req;
  logic        w_contend;
  logic        w_host_gnt;
  logic        w_dbg_gnt;
  logic        w_dbg_bypass;
  logic        w_dbg_acc;
  logic        w_dbg_ok;
  logic        w_key_match;
  logic [4:0]  w_fail_plus;
  logic        w_fail_hit;
  logic        w_idle_expire;
  logic        w_lo_done;

  function automatic logic [3:0] op_onehot(input logic [1:0] op);
    logic [3:0] oh;
    oh = 4'b0000;
    case (op)
      2'b00:   oh = 4'b0001;
      2'b01:   oh = 4'b0010;
      2'b10:   oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    return oh;
  endfunction

  // A relock in the same cycle closes the session before the command is judged.
  assign w_unlocked    = (r_state == S_UNLOCKED);
  assign w_permit      = w_unlocked && !dbg_relock;
  assign w_dbg_is_dp   = !dbg_op[2];
  assign w_dbg_is_read = (dbg_op == 3'b100);

  // Readies are qualified by rst_n so nothing is accepted while reset is held.
  assign w_host_req    = rst_n && host_valid;
  assign w_dbg_dp_req  = rst_n && dbg_valid && w_permit && w_dbg_is_dp;
  assign w_contend     = w_host_req && w_dbg_dp_req;
  assign w_host_gnt    = w_host_req && (!w_dbg_dp_req || !r_rr_ptr);
  assign w_dbg_gnt     = w_dbg_dp_req && (!w_host_req || r_rr_ptr);
  // READ, reserved ops and anything while not unlocked never touch the datapath.
  assign w_dbg_bypass  = rst_n && dbg_valid && !w_dbg_dp_req;
  assign w_dbg_acc     = w_dbg_gnt || w_dbg_bypass;
  assign w_dbg_ok      = w_permit && (w_dbg_is_dp || w_dbg_is_read);

  assign w_key_match   = (r_key == UNLOCK_KEY);
  assign w_fail_plus   = {1'b0, r_fail} + 5'd1;
  assign w_fail_hit    = (w_fail_plus == 5'(MAX_FAIL));
  assign w_idle_expire = (r_idle == IDLE_W'(SESSION_TIMEOUT - 1));
  assign w_lo_done     = (r_lo_cnt == LO_W'(LOCKOUT_CYCLES - 1));

  assign host_ready    = w_host_gnt;
  assign dbg_ready     = w_dbg_acc;
  assign dbg_unlocked  = w_unlocked;
  assign dp_control    = r_dp_control;
  assign dp_data       = r_dp_data;
  assign dbg_rsp_valid = r_rsp_valid;
  assign dbg_rsp_err   = r_rsp_err;
  // READ returns the accumulator as it stands in the response cycle.
  assign dbg_rsp_data  = r_rsp_read ? dp_result : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOCKED;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOCKED: begin
        if (dbg_unlock) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_key_match)     w_state_nxt = S_UNLOCKED;
        else if (w_fail_hit) w_state_nxt = S_LOCKOUT;
        else                 w_state_nxt = S_LOCKED;
      end
      S_UNLOCKED: begin
        // An accepted command restarts the idle timer, so it also holds off expiry.
        if (dbg_relock)                      w_state_nxt = S_LOCKED;
        else if (!w_dbg_acc && w_idle_expire) w_state_nxt = S_LOCKED;
      end
      S_LOCKOUT: begin
        if (w_lo_done) w_state_nxt = S_LOCKED;
      end
      default: w_state_nxt = S_LOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key    <= 32'h0;
      r_fail   <= 4'h0;
      r_lo_cnt <= '0;
      r_idle   <= '0;
      r_rr_ptr <= 1'b0;
    end else begin
      if (r_state == S_LOCKED && dbg_unlock) r_key <= dbg_key;

      if (r_state == S_CHECK) begin
        if (w_key_match)          r_fail <= 4'h0;
        else if (r_fail != 4'hF)  r_fail <= w_fail_plus[3:0];
      end else if (r_state == S_LOCKOUT && w_lo_done) begin
        r_fail <= 4'h0;
      end

      if (r_state == S_LOCKOUT && !w_lo_done) r_lo_cnt <= r_lo_cnt + LO_W'(1);
      else                                    r_lo_cnt <= '0;

      if (r_state != S_UNLOCKED || w_dbg_acc) r_idle <= '0;
      else if (!w_idle_expire)                r_idle <= r_idle + IDLE_W'(1);

      if (w_contend) r_rr_ptr <= !r_rr_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_control <= 4'b0000;
      r_dp_data    <= 32'h0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_read   <= 1'b0;
    end else begin
      if (w_host_gnt) begin
        r_dp_control <= op_onehot(host_op);
        r_dp_data    <= host_data;
      end else if (w_dbg_gnt) begin
        r_dp_control <= op_onehot(dbg_op[1:0]);
        r_dp_data    <= dbg_data;
      end else begin
        r_dp_control <= 4'b0000;
        r_dp_data    <= 32'h0;
      end
      r_rsp_valid <= w_dbg_acc;
      r_rsp_err   <= w_dbg_acc && !w_dbg_ok;
      r_rsp_read  <= w_dbg_acc && w_permit && w_dbg_is_read;
    end
  end

endmodule
